// File: rtl/conv_engine_seq.sv
`default_nettype none
// ============================================================================
// Module   : conv_engine_seq
// Brief    : Sequential N x N convolution (one MAC per cycle) of an unsigned
//            pixel matrix with a signed kernel, with wrap or clamp output.
// Revision : 1.0 - initial release
// ============================================================================
module conv_engine_seq #(
  parameter int DATA_W   = 8,
  parameter int MAX_N    = 5,
  parameter int ACC_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [1:0]                      matrix_size,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   matrix_a,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   matrix_b,
  output logic                            busy,
  output logic                            done,
  output logic [ACC_W-1:0]                result,
  output logic                            overflow,
  output logic                            size_err
);

  localparam int VEC_W  = MAX_N*MAX_N*DATA_W;
  localparam int PROD_W = 2*DATA_W+1;
  // 5 guard bits cover the 25 products of the largest 5x5 matrix
  localparam int SUM_W  = 2*DATA_W+1+5;
  // one bit wider than both the accumulator and the output for safe compares
  localparam int CMP_W  = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

  localparam logic signed [CMP_W-1:0] C_ONE = CMP_W'(1);
  localparam logic signed [CMP_W-1:0] C_MAX = (C_ONE <<< (ACC_W-1)) - C_ONE;
  localparam logic signed [CMP_W-1:0] C_MIN = -(C_ONE <<< (ACC_W-1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [VEC_W-1:0]         a_reg, b_reg;
  logic [2:0]               n_reg;
  logic [2:0]               row, col;
  logic signed [SUM_W-1:0]  acc;
  logic [ACC_W-1:0]         result_reg;
  logic                     overflow_reg;
  logic                     size_err_reg;

  logic [2:0]               n_req;
  logic                     size_bad;
  logic                     start_ok;
  logic                     last_elem;
  logic [31:0]              elem_off;
  logic [DATA_W-1:0]        a_elem, b_elem;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  acc_next;
  logic signed [CMP_W-1:0]  acc_wide;
  logic                     ovf_w;
  logic [ACC_W-1:0]         res_w;

  assign n_req     = {1'b0, matrix_size} + 3'd2;
  assign size_bad  = (n_req > 3'(MAX_N));
  // start is only looked at when no operation is in flight
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign last_elem = (row == n_reg - 3'd1) && (col == n_reg - 3'd1);

  // element (row,col) lives at the MAX_N pitch regardless of the active size
  assign elem_off  = (32'(row) * 32'(MAX_N) + 32'(col)) * 32'(DATA_W);
  assign a_elem    = a_reg[elem_off +: DATA_W];
  assign b_elem    = b_reg[elem_off +: DATA_W];
  assign prod      = PROD_W'($signed({1'b0, a_elem})) * PROD_W'($signed(b_elem));
  assign acc_next  = acc + SUM_W'(prod);
  assign acc_wide  = CMP_W'(acc_next);

  // range check and wrap/clamp of the sum that includes the current product
  always_comb begin
    ovf_w = (acc_wide > C_MAX) || (acc_wide < C_MIN);
    res_w = acc_wide[ACC_W-1:0];
    if (ovf_w && (SATURATE != 0)) begin
      res_w = (acc_wide > C_MAX) ? C_MAX[ACC_W-1:0] : C_MIN[ACC_W-1:0];
    end
  end

  // next-state selection: IDLE -> RUN/DONE, RUN -> DONE on last MAC, DONE -> IDLE/RUN
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = size_bad ? DONE : RUN;
      end
      RUN: begin
        if (last_elem) state_next = DONE;
      end
      DONE: begin
        if (start) state_next = size_bad ? DONE : RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // state register, operand capture, MAC datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      n_reg        <= 3'd0;
      row          <= 3'd0;
      col          <= 3'd0;
      acc          <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      size_err_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        a_reg <= matrix_a;
        b_reg <= matrix_b;
        n_reg <= n_req;
        acc   <= '0;
        row   <= 3'd0;
        col   <= 3'd0;
        if (size_bad) begin
          result_reg   <= '0;
          overflow_reg <= 1'b0;
          size_err_reg <= 1'b1;
        end
      end else if (state == RUN) begin
        acc <= acc_next;
        if (col == n_reg - 3'd1) begin
          col <= 3'd0;
          row <= row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
        if (last_elem) begin
          result_reg   <= res_w;
          overflow_reg <= ovf_w;
          size_err_reg <= 1'b0;
        end
      end
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign result   = result_reg;
  assign overflow = overflow_reg;
  assign size_err = size_err_reg;

endmodule
`default_nettype wire

// File: tb/tb_conv_engine_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_engine_seq
// Brief    : Self-checking bench for conv_engine_seq (wrap, clamp and
//            reduced-MAX_N instances) against a plain-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_engine_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic [1:0]   matrix_size;
  logic [199:0] matrix_a, matrix_b;
  logic         busy, done, overflow, size_err;
  logic [15:0]  result;
  logic         busy_s, done_s, overflow_s, size_err_s;
  logic [15:0]  result_s;
  logic         start3;
  logic [1:0]   size3;
  logic [71:0]  a3, b3;
  logic         busy3, done3, overflow3, size_err3;
  logic [15:0]  result3;

  conv_engine_seq #(.DATA_W(8), .MAX_N(5), .ACC_W(16), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_size(matrix_size),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .busy(busy), .done(done),
    .result(result), .overflow(overflow), .size_err(size_err));

  conv_engine_seq #(.DATA_W(8), .MAX_N(5), .ACC_W(16), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_size(matrix_size),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .busy(busy_s), .done(done_s),
    .result(result_s), .overflow(overflow_s), .size_err(size_err_s));

  conv_engine_seq #(.DATA_W(8), .MAX_N(3), .ACC_W(16), .SATURATE(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .matrix_size(size3),
    .matrix_a(a3), .matrix_b(b3), .busy(busy3), .done(done3),
    .result(result3), .overflow(overflow3), .size_err(size_err3));

  int total = 0;
  int bad   = 0;
  int am [5][5];
  int bm [5][5];

  function automatic logic [199:0] pack_a();
    logic [199:0] v;
    int t;
    v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        t = am[r][c];
        v[(r*5+c)*8 +: 8] = t[7:0];
      end
    return v;
  endfunction

  function automatic logic [199:0] pack_b();
    logic [199:0] v;
    int t;
    v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        t = bm[r][c];
        v[(r*5+c)*8 +: 8] = t[7:0];
      end
    return v;
  endfunction

  function automatic logic [71:0] pack3(input bit is_b);
    logic [71:0] v;
    int t;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        t = is_b ? bm[r][c] : am[r][c];
        v[(r*3+c)*8 +: 8] = t[7:0];
      end
    return v;
  endfunction

  function automatic logic [199:0] rnd_vec();
    logic [199:0] v;
    v = '0;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  function automatic void fill_random();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        am[r][c] = int'($urandom_range(0, 255));
        bm[r][c] = int'($urandom_range(0, 255)) - 128;
      end
  endfunction

  function automatic void fill_const(input int av, input int bv);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        am[r][c] = av;
        bm[r][c] = bv;
      end
  endfunction

  // exact mathematical convolution sum over the leading n x n block
  function automatic longint model_sum(input int n);
    longint s;
    s = 0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        s += longint'(am[r][c]) * longint'(bm[r][c]);
    return s;
  endfunction

  function automatic logic [15:0] wrap16(input longint s);
    logic [63:0] t;
    t = s;
    return t[15:0];
  endfunction

  function automatic logic [15:0] clamp16(input longint s);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return wrap16(s);
  endfunction

  function automatic logic is_ovf(input longint s);
    return (s > 32767) || (s < -32768);
  endfunction

  // one start pulse on the MAX_N=5 pair; returns latency, busy count and outputs at done
  task automatic do_conv(input int sel, output int lat, output int busy_cyc,
                         output logic [15:0] r0, output logic o0, output logic e0,
                         output logic [15:0] r1, output logic o1);
    @(negedge clk);
    matrix_size = 2'(sel);
    matrix_a    = pack_a();
    matrix_b    = pack_b();
    start       = 1'b1;
    lat = -1; busy_cyc = 0; r0 = '0; o0 = 1'b0; e0 = 1'b0; r1 = '0; o1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start    = 1'b0;
      matrix_a = rnd_vec();
      matrix_b = rnd_vec();
      if (busy) busy_cyc++;
      if (done) begin
        lat = k; r0 = result; o0 = overflow; e0 = size_err;
        r1 = result_s; o1 = overflow_s;
        break;
      end
    end
  endtask

  // one start pulse on the MAX_N=3 instance
  task automatic do_conv3(input int sel, output int lat, output int busy_cyc,
                          output logic [15:0] r0, output logic o0, output logic e0);
    @(negedge clk);
    size3  = 2'(sel);
    a3     = pack3(1'b0);
    b3     = pack3(1'b1);
    start3 = 1'b1;
    lat = -1; busy_cyc = 0; r0 = '0; o0 = 1'b0; e0 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      a3     = 72'(rnd_vec());
      b3     = 72'(rnd_vec());
      if (busy3) busy_cyc++;
      if (done3) begin
        lat = k; r0 = result3; o0 = overflow3; e0 = size_err3;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
    matrix_size = 2'd0; size3 = 2'd0;
    matrix_a = '0; matrix_b = '0; a3 = '0; b3 = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, result, overflow, size_err} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h ovf=%b serr=%b, expected all 0",
               busy, done, result, overflow, size_err);
    end
    total++;
    if ({busy3, done3, result3, overflow3, size_err3} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs_n3: got busy=%b done=%b result=%h, expected all 0",
               busy3, done3, result3);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_3x3();
    int lat, bc; logic [15:0] r0, r1; logic o0, e0, o1;
    fill_const(10, 1);
    do_conv(1, lat, bc, r0, o0, e0, r1, o1);
    total++; if (lat !== 10) begin bad++; $display("FAIL 3x3_latency: got %0d expected 10", lat); end
    total++; if (bc !== 9) begin bad++; $display("FAIL 3x3_busy: got %0d expected 9", bc); end
    total++; if (r0 !== 16'd90) begin bad++; $display("FAIL 3x3_result: got %0d expected 90", r0); end
    total++; if (o0 !== 1'b0) begin bad++; $display("FAIL 3x3_overflow: got %b expected 0", o0); end
  endtask

  task automatic test_5x5();
    int lat, bc; logic [15:0] r0, r1; logic o0, e0, o1;
    fill_const(100, -1);
    bm[2][2] = 8;
    do_conv(3, lat, bc, r0, o0, e0, r1, o1);
    total++; if (lat !== 26) begin bad++; $display("FAIL 5x5_latency: got %0d expected 26", lat); end
    total++; if (r0 !== 16'hF9C0) begin bad++; $display("FAIL 5x5_result: got %h expected f9c0", r0); end
    total++; if (r0 !== wrap16(model_sum(5))) begin bad++; $display("FAIL 5x5_model: got %h expected %h", r0, wrap16(model_sum(5))); end
  endtask

  task automatic test_overflow_2x2();
    int lat, bc; logic [15:0] r0, r1; logic o0, e0, o1;
    fill_const(255, -128);
    do_conv(0, lat, bc, r0, o0, e0, r1, o1);
    total++; if (lat !== 5) begin bad++; $display("FAIL ovf_latency: got %0d expected 5", lat); end
    total++; if (r0 !== 16'h0200) begin bad++; $display("FAIL ovf_wrap_result: got %h expected 0200", r0); end
    total++; if (o0 !== 1'b1) begin bad++; $display("FAIL ovf_wrap_flag: got %b expected 1", o0); end
    total++; if (r1 !== 16'h8000) begin bad++; $display("FAIL ovf_sat_result: got %h expected 8000", r1); end
    total++; if (o1 !== 1'b1) begin bad++; $display("FAIL ovf_sat_flag: got %b expected 1", o1); end
  endtask

  task automatic test_random();
    int lat, bc, sel, n; logic [15:0] r0, r1; logic o0, e0, o1; longint s;
    for (int it = 0; it < 12; it++) begin
      sel = int'($urandom_range(0, 3));
      n   = sel + 2;
      fill_random();
      if (it % 3 == 0) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) begin
            am[r][c] = int'($urandom_range(200, 255));
            bm[r][c] = (it % 2 == 0) ? int'($urandom_range(100, 127)) : -int'($urandom_range(100, 128));
          end
      end
      s = model_sum(n);
      do_conv(sel, lat, bc, r0, o0, e0, r1, o1);
      total++; if (lat !== n*n+1) begin bad++; $display("FAIL rand_latency: n=%0d got %0d expected %0d", n, lat, n*n+1); end
      total++; if (bc !== n*n) begin bad++; $display("FAIL rand_busy: n=%0d got %0d expected %0d", n, bc, n*n); end
      total++; if (r0 !== wrap16(s)) begin bad++; $display("FAIL rand_wrap: n=%0d got %h expected %h", n, r0, wrap16(s)); end
      total++; if (o0 !== is_ovf(s)) begin bad++; $display("FAIL rand_ovf: n=%0d got %b expected %b", n, o0, is_ovf(s)); end
      total++; if (r1 !== clamp16(s)) begin bad++; $display("FAIL rand_sat: n=%0d got %h expected %h", n, r1, clamp16(s)); end
      total++; if (o1 !== is_ovf(s)) begin bad++; $display("FAIL rand_sat_ovf: n=%0d got %b expected %b", n, o1, is_ovf(s)); end
      total++; if (e0 !== 1'b0) begin bad++; $display("FAIL rand_size_err: got %b expected 0", e0); end
    end
  endtask

  task automatic test_start_ignored();
    int lat; longint s;
    fill_random();
    s = model_sum(3);
    @(negedge clk);
    matrix_size = 2'd1; matrix_a = pack_a(); matrix_b = pack_b(); start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        total++;
        if (result !== wrap16(s)) begin bad++; $display("FAIL ignore_result: got %h expected %h", result, wrap16(s)); end
        start = 1'b0;
        break;
      end
      start       = 1'($urandom_range(0, 1));
      matrix_size = 2'($urandom_range(0, 3));
      matrix_a    = rnd_vec();
      matrix_b    = rnd_vec();
    end
    start = 1'b0;
    total++; if (lat !== 10) begin bad++; $display("FAIL ignore_latency: got %0d expected 10", lat); end
  endtask

  task automatic test_back_to_back();
    int ndone; longint s;
    fill_random();
    s = model_sum(3);
    @(negedge clk);
    matrix_size = 2'd1; matrix_a = pack_a(); matrix_b = pack_b(); start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        total++;
        if (k !== 10*ndone) begin bad++; $display("FAIL b2b_timing: done #%0d at %0d expected %0d", ndone, k, 10*ndone); end
        total++;
        if (result !== wrap16(s)) begin bad++; $display("FAIL b2b_result: got %h expected %h", result, wrap16(s)); end
        if (ndone == 3) begin start = 1'b0; break; end
      end
    end
    start = 1'b0;
    total++; if (ndone !== 3) begin bad++; $display("FAIL b2b_count: got %0d expected 3", ndone); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_reset_midrun();
    int lat, bc, late; logic [15:0] r0, r1; logic o0, e0, o1; longint s;
    fill_random();
    @(negedge clk);
    matrix_size = 2'd2; matrix_a = pack_a(); matrix_b = pack_b(); start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, result, overflow, size_err} !== 20'd0) begin
      bad++;
      $display("FAIL midrun_reset: got busy=%b done=%b result=%h ovf=%b serr=%b, expected all 0",
               busy, done, result, overflow, size_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    late = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) late++;
    end
    total++; if (late !== 0) begin bad++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", late); end
    fill_random();
    s = model_sum(4);
    do_conv(2, lat, bc, r0, o0, e0, r1, o1);
    total++; if (lat !== 17) begin bad++; $display("FAIL midrun_next_latency: got %0d expected 17", lat); end
    total++; if (r0 !== wrap16(s)) begin bad++; $display("FAIL midrun_next_result: got %h expected %h", r0, wrap16(s)); end
  endtask

  task automatic test_size_err();
    int lat, bc; logic [15:0] r0; logic o0, e0; longint s;
    fill_random();
    s = model_sum(3);
    do_conv3(1, lat, bc, r0, o0, e0);
    total++; if (lat !== 10) begin bad++; $display("FAIL n3_latency: got %0d expected 10", lat); end
    total++; if (r0 !== wrap16(s)) begin bad++; $display("FAIL n3_result: got %h expected %h", r0, wrap16(s)); end
    total++; if (e0 !== 1'b0) begin bad++; $display("FAIL n3_size_err: got %b expected 0", e0); end
    for (int sel = 3; sel >= 2; sel--) begin
      fill_random();
      do_conv3(sel, lat, bc, r0, o0, e0);
      total++; if (lat !== 1) begin bad++; $display("FAIL szerr_latency: sel=%0d got %0d expected 1", sel, lat); end
      total++; if (r0 !== 16'd0) begin bad++; $display("FAIL szerr_result: sel=%0d got %h expected 0", sel, r0); end
      total++; if (e0 !== 1'b1) begin bad++; $display("FAIL szerr_flag: sel=%0d got %b expected 1", sel, e0); end
      total++; if (o0 !== 1'b0) begin bad++; $display("FAIL szerr_ovf: sel=%0d got %b expected 0", sel, o0); end
      total++; if (bc !== 0) begin bad++; $display("FAIL szerr_busy: sel=%0d got %0d expected 0", sel, bc); end
    end
  endtask

  initial begin
    test_reset();
    test_3x3();
    test_5x5();
    test_overflow_2x2();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_size_err();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_engine_seq.md
CONV_ENGINE_SEQ -- requirements
Module: conv_engine_seq

Interface
REQ-001 Parameters (one per line: name, default, meaning):
- DATA_W, 8, width in bits of each pixel and kernel element.
- MAX_N, 5, largest supported square dimension; legal range 2..5.
- ACC_W, 16, width in bits of the result output.
- SATURATE, 0, selects the out-of-range result policy: 1 = clamp, 0 = two's-complement wrap.

REQ-002 Ports (one per line: name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- start, input, 1, request to begin one convolution.
- matrix_size, input, 2, dimension select: 00=2x2, 01=3x3, 10=4x4, 11=5x5.
- matrix_a, input, MAX_N*MAX_N*DATA_W, pixel elements, unsigned.
- matrix_b, input, MAX_N*MAX_N*DATA_W, kernel elements, signed two's-complement.
- busy, output, 1, high while a request is being processed.
- done, output, 1, one-cycle pulse that marks result as valid.
- result, output, ACC_W, signed convolution sum.
- overflow, output, 1, high when the exact sum does not fit in ACC_W signed bits.
- size_err, output, 1, high when the requested dimension exceeds MAX_N.

Function
REQ-003 Element (r,c) SHALL be stored at bit offset ((r*MAX_N)+c)*DATA_W in both matrix_a and matrix_b; layout is row-major at the MAX_N pitch for every size.
REQ-004 N SHALL equal matrix_size+2.
REQ-005 The computed value SHALL be the sum over r,c < N of zero-extended(a[r][c]) * signed(b[r][c]).
REQ-006 The FSM SHALL have exactly three states: IDLE, RUN and DONE; the reset state is IDLE.
REQ-007 start SHALL be sampled only in IDLE or DONE; start asserted in RUN SHALL be ignored with no side effects.
REQ-008 On an accepted start, the block SHALL register matrix_a, matrix_b and matrix_size, clear the accumulator, set the element counter to 0, and enter RUN; inputs may change freely after that edge.
REQ-009 RUN SHALL perform one MAC per cycle, in row-major order (r,c) = (0,0), (0,1), ..., (N-1,N-1).
REQ-010 After the MAC for element (N-1,N-1), RUN SHALL go to DONE.
REQ-011 done SHALL be high exactly N*N+1 cycles after the accepted start edge, and SHALL be high only in DONE.
REQ-012 DONE SHALL last one cycle, then go to IDLE, or to RUN if start is high in that cycle (back-to-back operation).
REQ-013 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-014 The internal accumulator SHALL be signed with width 2*DATA_W+1+5 bits, and SHALL never overflow for MAX_N ≤ 5.
REQ-015 On entry to DONE, result and overflow SHALL be registered from the accumulator; both SHALL hold until the next DONE or reset.
REQ-016 When the accumulator lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1], overflow SHALL be 1.
REQ-017 On overflow with SATURATE=1, result SHALL clamp to the nearest bound.
REQ-018 On overflow with SATURATE=0, result SHALL be the low ACC_W bits of the accumulator.
REQ-019 If N > MAX_N at an accepted start, the block SHALL skip RUN and go directly to DONE on the next edge, with result=0, overflow=0 and size_err=1.
REQ-020 size_err SHALL otherwise be 0, and SHALL hold with result.

Reset
REQ-021 While rst_n=0, the block SHALL immediately force the state to IDLE and force busy=0, done=0, result=0, overflow=0 and size_err=0, and SHALL clear the accumulator and element counter.
REQ-022 Reset asserted mid-RUN SHALL abandon the operation; no done pulse SHALL follow reset release.
REQ-023 The first start after reset release SHALL be honoured normally.

Verification (defaults unless stated)
REQ-024 3x3 case: size=01, all a=10, all b=1, start for 1 cycle -> busy high for 9 cycles; done 10 cycles after start; result=90; overflow=0.
REQ-025 5x5 case: size=11, all a=100, b center=8, other 24 b=-1 -> done after 26 cycles; result=-1600 (0xF9C0).
REQ-026 2x2 overflow case: size=00, all a=255, all b=-128 (sum -130560):
- SATURATE=0 -> result=0x0200, overflow=1.
- SATURATE=1 -> result=0x8000, overflow=1.
REQ-027 Handshake case: start held high continuously with 3x3 operands -> done pulses every 10 cycles; start pulses during RUN change neither timing nor result.
REQ-028 Reset mid-run case: rst_n low on cycle 4 of a 4x4 run -> all outputs 0 at once; no done after release; the next 4x4 start gives the correct sum after 17 cycles.
REQ-029 Size-error case: MAX_N=3, size=11 -> done 1 cycle after start; result=0; size_err=1; busy never high.
